span_cmd_writer: RTL and testbench

- Producer end of the paint-command queue in PRAM; the CPU-side counterpart of the span painter.
- Accepts rectangle-fill commands (x0, x1, y0, y1, color) over a valid/ready handshake.
- Sorts and clips the coordinates, then splits the rectangle into one span per pixel row.
- Writes each span as two consecutive 16-bit PRAM words into the 1024-entry circular queue and owns the queue write pointer, wrtPtr.

---
 rtl/span_cmd_writer_if.sv | 25 ++
 rtl/span_cmd_writer.sv | 146 ++++++++++++++
 tb/tb_span_cmd_writer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/span_cmd_writer_if.sv
// Rectangle-fill command channel into span_cmd_writer.
//   cmd_valid          : command present (master -> slave)
//   cmd_ready          : slave can take a command this cycle
//   cmd_x0 / cmd_x1    : unsorted column edges, 8 bits
//   cmd_y0 / cmd_y1    : unsorted row edges, 7 bits
//   cmd_color          : 3-bit pixel color
interface span_cmd_writer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x0;
  logic [7:0] cmd_x1;
  logic [6:0] cmd_y0;
  logic [6:0] cmd_y1;
  logic [2:0] cmd_color;

  modport master (
    output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    output cmd_ready
  );
endinterface

// File: rtl/span_cmd_writer.sv
// Producer end of the PRAM paint-command queue.
// Takes rectangle-fill commands, sorts and clips the corners, and expands the
// rectangle into one span per row. Each span is two 16-bit words written into
// a 2^DEPTH_LOG2-entry circular queue whose write pointer this block owns.
//   clk, reset : clock, synchronous active-high reset
//   cmd        : command channel (slave side)
//   rdPtr      : consumer read pointer
//   wrtPtr     : producer write pointer (registered)
//   pram_we/pram_addr/pram_wdata : PRAM write port
//   full       : no free slot (one slot is always left empty)
//   busy       : a command is being expanded
//   dropped    : one-cycle pulse, accepted command was wholly off-screen
module span_cmd_writer #(
  parameter int X_MAX      = 127,
  parameter int Y_MAX      = 119,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  span_cmd_writer_if.slave      cmd,
  input  logic [DEPTH_LOG2-1:0] rdPtr,
  output logic [DEPTH_LOG2-1:0] wrtPtr,
  output logic                  pram_we,
  output logic [DEPTH_LOG2-1:0] pram_addr,
  output logic [15:0]           pram_wdata,
  output logic                  full,
  output logic                  busy,
  output logic                  dropped
);

  localparam logic [7:0]            XMAX8 = 8'(X_MAX);
  localparam logic [6:0]            YMAX7 = 7'(Y_MAX);
  localparam logic [DEPTH_LOG2-1:0] PONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {IDLE, W1, W2} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [6:0]            lo_x_q, lo_x_d;
  logic [6:0]            hi_x_q, hi_x_d;
  logic [6:0]            row_q, row_d;
  logic [6:0]            hi_y_q, hi_y_d;
  logic [2:0]            color_q, color_d;
  logic                  dropped_q, dropped_d;

  logic [7:0] s_lo_x, s_hi_x, c_hi_x;
  logic [6:0] s_lo_y, s_hi_y, c_hi_y;
  logic       space, accept, off_screen;

  // Wrap-around compare: one slot stays empty so wptr==rdPtr means empty.
  assign space  = (wptr_q + PONE) != rdPtr;
  assign full   = ~space;
  assign busy   = (state_q != IDLE);
  assign wrtPtr = wptr_q;
  assign dropped = dropped_q;

  assign cmd.cmd_ready = (state_q == IDLE) && !reset;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // Sort the corners, then clip the high edges to the screen.
  always_comb begin
    s_lo_x = (cmd.cmd_x0 < cmd.cmd_x1) ? cmd.cmd_x0 : cmd.cmd_x1;
    s_hi_x = (cmd.cmd_x0 < cmd.cmd_x1) ? cmd.cmd_x1 : cmd.cmd_x0;
    s_lo_y = (cmd.cmd_y0 < cmd.cmd_y1) ? cmd.cmd_y0 : cmd.cmd_y1;
    s_hi_y = (cmd.cmd_y0 < cmd.cmd_y1) ? cmd.cmd_y1 : cmd.cmd_y0;
    c_hi_x = (s_hi_x > XMAX8) ? XMAX8 : s_hi_x;
    c_hi_y = (s_hi_y > YMAX7) ? YMAX7 : s_hi_y;
    off_screen = (s_lo_x > XMAX8) || (s_lo_y > YMAX7);
  end

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    lo_x_d     = lo_x_q;
    hi_x_d     = hi_x_q;
    row_d      = row_q;
    hi_y_d     = hi_y_q;
    color_d    = color_q;
    dropped_d  = 1'b0;
    pram_we    = 1'b0;
    pram_addr  = wptr_q;
    pram_wdata = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (off_screen) begin
            dropped_d = 1'b1;
          end else begin
            lo_x_d  = s_lo_x[6:0];
            hi_x_d  = c_hi_x[6:0];
            row_d   = s_lo_y;
            hi_y_d  = c_hi_y;
            color_d = cmd.cmd_color;
            state_d = W1;
          end
        end
      end
      W1: begin
        pram_wdata = {2'b00, lo_x_q, hi_x_q};
        // Pointer advances on the same edge PRAM latches the word.
        if (space) begin
          pram_we = 1'b1;
          wptr_d  = wptr_q + PONE;
          state_d = W2;
        end
      end
      W2: begin
        pram_wdata = {6'b0, row_q, color_q};
        if (space) begin
          pram_we = 1'b1;
          wptr_d  = wptr_q + PONE;
          if (row_q == hi_y_q) begin
            state_d = IDLE;
          end else begin
            row_d   = row_q + 7'd1;
            state_d = W1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      lo_x_q    <= '0;
      hi_x_q    <= '0;
      row_q     <= '0;
      hi_y_q    <= '0;
      color_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      lo_x_q    <= lo_x_d;
      hi_x_q    <= hi_x_d;
      row_q     <= row_d;
      hi_y_q    <= hi_y_d;
      color_q   <= color_d;
      dropped_q <= dropped_d;
    end
  end

endmodule

// File: tb/tb_span_cmd_writer.sv
module tb_span_cmd_writer;

  typedef struct {
    logic [7:0]  x0, x1;
    logic [6:0]  y0, y1;
    logic [2:0]  c;
    logic        drop;
    int          nrows;
    int          row0;
    logic [15:0] w1;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rdPtr;
  logic [9:0]  wrtPtr;
  logic        pram_we;
  logic [9:0]  pram_addr;
  logic [15:0] pram_wdata;
  logic        full, busy, dropped;

  int n_vec = 0;
  int n_bad = 0;
  int exp_ptr = 0;

  span_cmd_writer_if cmd_if();

  span_cmd_writer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd_if),
    .rdPtr      (rdPtr),
    .wrtPtr     (wrtPtr),
    .pram_we    (pram_we),
    .pram_addr  (pram_addr),
    .pram_wdata (pram_wdata),
    .full       (full),
    .busy       (busy),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    chk("ready_before_accept", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_x0    = v.x0;
    cmd_if.cmd_x1    = v.x1;
    cmd_if.cmd_y0    = v.y0;
    cmd_if.cmd_y1    = v.y1;
    cmd_if.cmd_color = v.c;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_x0 = 8'hEE;
    cmd_if.cmd_y0 = 7'h55;
    cmd_if.cmd_color = 3'd0;
    @(negedge clk);
  endtask

  // Check one expected word at the current negedge, then step to the next one.
  task automatic expect_word(input logic [15:0] w);
    chk("pram_we", 32'(pram_we), 32'd1);
    chk("pram_addr", 32'(pram_addr), 32'(exp_ptr));
    chk("pram_wdata", 32'(pram_wdata), 32'(w));
    chk("busy_during", 32'(busy), 32'd1);
    exp_ptr = (exp_ptr + 1) % 1024;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    drive(v);
    if (v.drop) begin
      chk("dropped_pulse", 32'(dropped), 32'd1);
      chk("drop_no_we", 32'(pram_we), 32'd0);
      chk("drop_busy", 32'(busy), 32'd0);
      chk("drop_ready", 32'(cmd_if.cmd_ready), 32'd1);
      @(negedge clk);
      chk("dropped_once", 32'(dropped), 32'd0);
      chk("drop_no_we2", 32'(pram_we), 32'd0);
    end else begin
      for (int r = 0; r < v.nrows; r++) begin
        expect_word(v.w1);
        expect_word((16'(v.row0 + r) << 3) | 16'(v.c));
      end
      chk("busy_end", 32'(busy), 32'd0);
      chk("no_we_end", 32'(pram_we), 32'd0);
    end
    chk("wrtPtr", 32'(wrtPtr), 32'(exp_ptr));
  endtask

  vec_t vt[7];

  initial begin
    vec_t v;
    // x0,x1,y0,y1,color, drop, nrows, row0, first word
    vt[0] = '{8'd10,  8'd20,  7'd5,   7'd5,   3'd3, 1'b0, 1, 5,   16'h0514};
    vt[1] = '{8'd30,  8'd4,   7'd9,   7'd7,   3'd1, 1'b0, 3, 7,   16'h021E};
    vt[2] = '{8'd100, 8'd200, 7'd118, 7'd125, 3'd2, 1'b0, 2, 118, 16'h327F};
    vt[3] = '{8'd130, 8'd140, 7'd0,   7'd0,   3'd6, 1'b1, 0, 0,   16'h0000};
    vt[4] = '{8'd50,  8'd50,  7'd60,  7'd60,  3'd7, 1'b0, 1, 60,  16'h1932};
    vt[5] = '{8'd3,   8'd9,   7'd120, 7'd126, 3'd2, 1'b1, 0, 0,   16'h0000};
    vt[6] = '{8'd200, 8'd127, 7'd119, 7'd119, 3'd4, 1'b0, 1, 119, 16'h3FFF};

    reset = 1'b1;
    rdPtr = '0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_x0 = '0; cmd_if.cmd_x1 = '0;
    cmd_if.cmd_y0 = '0; cmd_if.cmd_y1 = '0;
    cmd_if.cmd_color = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wrtPtr", 32'(wrtPtr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(pram_we), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    chk("rst_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    reset = 1'b0;
    #1 chk("ready_after_rst", 32'(cmd_if.cmd_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Fill up to wrtPtr=1022 with the consumer parked at 1023.
    rdPtr = 10'd1023;
    while (exp_ptr < 1022) begin
      int rows;
      rows = (1022 - exp_ptr) / 2;
      if (rows > 120) rows = 120;
      v = '{8'd0, 8'd127, 7'd0, 7'(rows - 1), 3'd4, 1'b0, rows, 0, 16'h007F};
      run_vec(v);
    end
    chk("fill_full", 32'(full), 32'd1);

    // Full stall in W1, then release across the wrap.
    v = '{8'd2, 8'd1, 7'd3, 7'd3, 3'd5, 1'b0, 1, 3, 16'h0082};
    drive(v);
    for (int i = 0; i < 3; i++) begin
      chk("stall_full", 32'(full), 32'd1);
      chk("stall_we", 32'(pram_we), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_wrtPtr", 32'(wrtPtr), 32'd1022);
      @(negedge clk);
    end
    rdPtr = 10'd1;
    #1;
    expect_word(16'h0082);
    expect_word(16'h001D);
    chk("wrap_wrtPtr", 32'(wrtPtr), 32'd0);
    chk("wrap_busy", 32'(busy), 32'd0);
    chk("wrap_full", 32'(full), 32'd1);
    chk("wrap_no_we", 32'(pram_we), 32'd0);
    @(negedge clk);
    chk("wrap_stopped", 32'(wrtPtr), 32'd0);

    // Reset during W2 of a 10-row rectangle.
    rdPtr = 10'd0;
    run_vec(vt[0]);
    v = '{8'd5, 8'd6, 7'd0, 7'd9, 3'd1, 1'b0, 10, 0, 16'h0286};
    drive(v);
    expect_word(16'h0286);
    expect_word(16'h0001);
    expect_word(16'h0286);
    chk("pre_rst_we", 32'(pram_we), 32'd1);
    chk("pre_rst_addr", 32'(pram_addr), 32'd5);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_wrtPtr", 32'(wrtPtr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_we", 32'(pram_we), 32'd0);
    chk("mid_rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
    reset = 1'b0;
    exp_ptr = 0;
    run_vec(vt[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
